// File: rtl/dual_port_test_mem.sv
// dual_port_test_mem: two-port little-endian byte memory responder with a
// fixed-latency response pipeline on each port.
// Optional random request stalling: define DUAL_PORT_TEST_MEM_RANDOM_STALL_EN.

// Per-port response pipeline: LATENCY-deep shift register, no backpressure.
module dual_port_test_mem_resp_pipe #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_i,
  input  logic [34:0] msg_i,
  output logic        val_o,
  output logic [34:0] msg_o
);
  logic [LATENCY-1:0]       vld_pipe_q;
  logic [LATENCY-1:0][34:0] msg_pipe_q;

  // Shift valid and message one stage per cycle; idle slots carry zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      msg_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= acc_i;
      msg_pipe_q[0] <= acc_i ? msg_i : 35'h0;
      for (int s = 1; s < LATENCY; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        msg_pipe_q[s] <= msg_pipe_q[s-1];
      end
    end
  end

  assign val_o = vld_pipe_q[LATENCY-1];
  assign msg_o = msg_pipe_q[LATENCY-1];
endmodule

module dual_port_test_mem #(
  parameter int          SIZE      = 65536,
  parameter int          LATENCY   = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [66:0] memreq0_msg,
  input  logic        memreq0_val,
  output logic        memreq0_rdy,
  output logic [34:0] memresp0_msg,
  output logic        memresp0_val,
  input  logic [66:0] memreq1_msg,
  input  logic        memreq1_val,
  output logic        memreq1_rdy,
  output logic [34:0] memresp1_msg,
  output logic        memresp1_val
);
  localparam int AW = $clog2(SIZE);

  // Byte array; intentionally never reset so a harness preload survives.
  logic [7:0] mem_q [SIZE];

  logic [1:0][66:0] req_msg;
  logic [1:0]       req_val, req_rdy, acc;
  logic [1:0]       req_typ;
  logic [1:0][1:0]  req_len;
  logic [1:0][AW-1:0] req_base;
  logic [1:0][31:0] req_wdata, rdata;
  logic [1:0][3:0]  req_be;
  logic [1:0][34:0] resp_msg, pipe_msg;
  logic [1:0]       pipe_val;

  assign req_msg = {memreq1_msg, memreq0_msg};
  assign req_val = {memreq1_val, memreq0_val};

  // Upper address bits beyond the array size are don't-care (address wraps).
  logic unused_addr;
  assign unused_addr = ^{req_msg[0][65:34+AW], req_msg[1][65:34+AW]};

  // Field decode; len 0 means a full word, otherwise that many low bytes.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      req_typ[p]   = req_msg[p][66];
      req_base[p]  = req_msg[p][34+AW-1:34];
      req_len[p]   = req_msg[p][33:32];
      req_wdata[p] = req_msg[p][31:0];
      unique case (req_len[p])
        2'd1:    req_be[p] = 4'b0001;
        2'd2:    req_be[p] = 4'b0011;
        2'd3:    req_be[p] = 4'b0111;
        default: req_be[p] = 4'b1111;
      endcase
      acc[p] = req_val[p] && req_rdy[p] && !reset;
    end
  end

  // Read path sees pre-edge contents, so same-edge writes are not forwarded.
  always_comb begin
    logic [AW-1:0] idx;
    idx   = '0;
    rdata = '0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) begin
        idx = req_base[p] + AW'(k);
        rdata[p][8*k +: 8] = req_be[p][k] ? mem_q[idx] : 8'h00;
      end
    end
  end

  // Byte writes; port 1 is applied last so it wins on overlapping bytes.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (acc[p] && req_typ[p]) begin
        for (int k = 0; k < 4; k++) begin
          if (req_be[p][k]) mem_q[req_base[p] + AW'(k)] <= req_wdata[p][8*k +: 8];
        end
      end
    end
  end

  // Response message: echo type and len; writes return zero data.
  always_comb begin
    for (int p = 0; p < 2; p++)
      resp_msg[p] = {req_typ[p], req_len[p], req_typ[p] ? 32'h0 : rdata[p]};
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    dual_port_test_mem_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
      .clk   (clk),
      .rst   (reset),
      .acc_i (acc[p]),
      .msg_i (resp_msg[p]),
      .val_o (pipe_val[p]),
      .msg_o (pipe_msg[p])
    );
  end

  assign memresp0_val = pipe_val[0];
  assign memresp0_msg = pipe_msg[0];
  assign memresp1_val = pipe_val[1];
  assign memresp1_msg = pipe_msg[1];

`ifdef DUAL_PORT_TEST_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11, right-shifting form.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // LFSR state register, free-running every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign req_rdy = {~lfsr_q[7], ~lfsr_q[0]};
`else
  localparam logic [15:0] unused_seed = LFSR_SEED;
  assign req_rdy = {2{~reset}};
`endif

  assign memreq0_rdy = req_rdy[0];
  assign memreq1_rdy = req_rdy[1];
endmodule
